imem_fetch_ctrl: RTL and testbench

//  Sequences the combinational instruction memory for the pipelined core.

---
 rtl/imem_fetch_if.sv | 27 ++
 rtl/imem_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// Fetch-side bundle: instruction-memory port, ID handshake and status shared by
// the fetch controller (master) and its surroundings (slave).
interface imem_fetch_if #(
  parameter int XLEN = 64
);
  logic            fetch_en;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            fault;
  logic            busy;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_rdata, id_ready,
    output imem_addr, id_valid, id_instr, id_pc, fault, busy
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_rdata, id_ready,
    input  imem_addr, id_valid, id_instr, id_pc, fault, busy
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the combinational IMEM and
// buffers {pc, instr} pairs in a small FIFO toward IF/ID, with redirect and fault handling.
module imem_fetch_ctrl #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_DEPTH = 64,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_fetch_if.master bus
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-3:0] DEPTH_W  = (XLEN-2)'(IMEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;

  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [31:0]     instr_mem [FIFO_DEPTH];

  logic empty, full, push, pop, flush, in_range, redir_misaligned;

  assign empty            = (cnt_q == '0);
  assign full             = (cnt_q == FULL_CNT);
  assign pop              = ~empty & bus.id_ready;
  assign in_range         = (pc_q[XLEN-1:2] < DEPTH_W);
  assign redir_misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // Redirect outranks everything except HALT; an out-of-range PC faults even when the FIFO is full.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    flush   = 1'b0;
    push    = 1'b0;
    if (state_q != S_HALT && bus.redirect_valid) begin
      flush = 1'b1;
      pc_d  = bus.redirect_pc;
      if (redir_misaligned) begin
        fault_d = 1'b1;
        state_d = S_HALT;
      end else if (state_q == S_FETCH && !bus.fetch_en) begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.fetch_en) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (!in_range) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            push = ~full | pop;
            if (push) pc_d = pc_q + XLEN'(4);
            if (!bus.fetch_en) state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= pc_q;
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_addr = {2'b00, pc_q[XLEN-1:2]};
  assign bus.id_valid  = ~empty;
  assign bus.id_instr  = empty ? 32'h0 : instr_mem[rd_ptr_q];
  assign bus.id_pc     = empty ? '0 : pc_mem[rd_ptr_q];
  assign bus.fault     = fault_q;
  assign bus.busy      = (state_q == S_FETCH);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_imem_fetch_ctrl;
  localparam int XL    = 64;
  localparam int DEPTH = 16;
  localparam int FD    = 2;

  logic clk;
  logic rst_n;
  logic [31:0] mem [DEPTH];

  imem_fetch_if #(.XLEN(XL)) bus ();

  imem_fetch_ctrl #(
    .XLEN(XL), .RESET_PC('0), .IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  assign bus.imem_rdata = (bus.imem_addr < 64'(DEPTH)) ? mem[bus.imem_addr[3:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched pairs plus running/halted flags.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc;
  bit          m_run, m_halt, m_fault;

  task automatic model_step();
    bit   pop;
    ent_t e;
    if (!rst_n) begin
      m_q.delete();
      m_pc = '0; m_run = 0; m_halt = 0; m_fault = 0;
    end else begin
      pop = (m_q.size() > 0) && bus.id_ready;
      if (m_halt) begin
        if (pop) void'(m_q.pop_front());
      end else if (bus.redirect_valid) begin
        m_q.delete();
        m_pc = bus.redirect_pc;
        if (bus.redirect_pc % 4 != 0) begin
          m_halt = 1; m_fault = 1; m_run = 0;
        end else if (!bus.fetch_en) begin
          m_run = 0;
        end
      end else if (m_run) begin
        if (pop) void'(m_q.pop_front());
        if ((m_pc >> 2) >= 64'(DEPTH)) begin
          m_halt = 1; m_fault = 1; m_run = 0;
        end else begin
          if (m_q.size() < FD) begin
            e.pc    = m_pc;
            e.instr = mem[m_pc[5:2]];
            m_q.push_back(e);
            m_pc = m_pc + 64'd4;
          end
          if (!bus.fetch_en) m_run = 0;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (bus.fetch_en) m_run = 1;
      end
    end
  endtask

  initial begin
    m_pc = '0; m_run = 0; m_halt = 0; m_fault = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial begin
    bit          ev;
    logic [63:0] epc;
    logic [31:0] ein;
    forever begin
      @(negedge clk);
      ev  = (m_q.size() > 0);
      epc = ev ? m_q[0].pc : 64'h0;
      ein = ev ? m_q[0].instr : 32'h0;
      chk("m_id_valid", 64'(bus.id_valid), 64'(ev));
      chk("m_id_pc", bus.id_pc, epc);
      chk("m_id_instr", 64'(bus.id_instr), 64'(ein));
      chk("m_fault", 64'(bus.fault), 64'(m_fault));
      chk("m_busy", 64'(bus.busy), 64'(m_run));
      chk("m_imem_addr", bus.imem_addr, m_pc >> 2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    rst_n              = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 1);
    rst_n = 1'b0;
    do_reset();
    chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_id_pc", bus.id_pc, 64'd0);
    chk("rst_id_instr", 64'(bus.id_instr), 64'd0);
    chk("rst_fault", 64'(bus.fault), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_imem_addr", bus.imem_addr, 64'd0);

    // Streaming fetch with ID always ready
    bus.fetch_en = 1'b1; bus.id_ready = 1'b1;
    step();
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_first_invalid", 64'(bus.id_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t1_valid", 64'(bus.id_valid), 64'd1);
      chk("t1_pc", bus.id_pc, 64'(4 * k));
      chk("t1_instr", 64'(bus.id_instr), 64'(k + 1));
    end

    // Backpressure fills the buffer and freezes the PC
    do_reset();
    bus.fetch_en = 1'b1; bus.id_ready = 1'b0;
    for (int k = 0; k < 7; k++) step();
    chk("t2_hold_pc", bus.id_pc, 64'h0);
    chk("t2_hold_instr", 64'(bus.id_instr), 64'd1);
    chk("t2_hold_addr", bus.imem_addr, 64'd2);
    bus.id_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      chk("t2_drain_pc", bus.id_pc, 64'(4 * k));
      chk("t2_drain_instr", 64'(bus.id_instr), 64'(k + 1));
    end

    // Redirect flushes a full buffer
    do_reset();
    bus.fetch_en = 1'b1; bus.id_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("t3_full_pc", bus.id_pc, 64'h0);
    bus.id_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h20;
    step();
    bus.redirect_valid = 1'b0;
    chk("t3_flush_valid", 64'(bus.id_valid), 64'd0);
    chk("t3_flush_addr", bus.imem_addr, 64'd8);
    step();
    chk("t3_new_valid", 64'(bus.id_valid), 64'd1);
    chk("t3_new_pc", bus.id_pc, 64'h20);
    chk("t3_new_instr", 64'(bus.id_instr), 64'd9);

    // Running off the end of IMEM faults; buffered entries still drain
    do_reset();
    bus.fetch_en = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h38;
    step();
    chk("t4_idle_redir_busy", 64'(bus.busy), 64'd0);
    chk("t4_idle_redir_addr", bus.imem_addr, 64'hE);
    bus.redirect_valid = 1'b0; bus.id_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("t4_pre_fault", 64'(bus.fault), 64'd0);
    chk("t4_pre_addr", bus.imem_addr, 64'h10);
    step();
    chk("t4_fault", 64'(bus.fault), 64'd1);
    chk("t4_halt_busy", 64'(bus.busy), 64'd0);
    chk("t4_buf_pc0", bus.id_pc, 64'h38);
    bus.id_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h0;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4_buf_pc1", bus.id_pc, 64'h3C);
    chk("t4_buf_instr1", 64'(bus.id_instr), 64'd16);
    chk("t4_redir_ignored", bus.imem_addr, 64'h10);
    step();
    chk("t4_drained", 64'(bus.id_valid), 64'd0);
    chk("t4_fault_sticky", 64'(bus.fault), 64'd1);

    // Misaligned redirect
    do_reset();
    bus.fetch_en = 1'b1;
    step();
    step();
    chk("t5_has_entry", 64'(bus.id_valid), 64'd1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h22;
    step();
    bus.redirect_valid = 1'b0;
    chk("t5_fault", 64'(bus.fault), 64'd1);
    chk("t5_flushed", 64'(bus.id_valid), 64'd0);
    chk("t5_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset between edges
    do_reset();
    bus.fetch_en = 1'b1; bus.id_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("t6_running_pc", bus.id_pc, 64'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(bus.id_valid), 64'd0);
    chk("t6_async_pc", bus.id_pc, 64'd0);
    chk("t6_async_instr", 64'(bus.id_instr), 64'd0);
    chk("t6_async_busy", 64'(bus.busy), 64'd0);
    chk("t6_async_addr", bus.imem_addr, 64'd0);
    rst_n = 1'b1;
    step();
    chk("t6_restart_busy", 64'(bus.busy), 64'd1);
    step();
    chk("t6_restart_pc", bus.id_pc, 64'd0);
    chk("t6_restart_instr", 64'(bus.id_instr), 64'd1);

    // Randomized traffic, checked by the per-cycle model comparison
    for (int ep = 0; ep < 10; ep++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      do_reset();
      for (int c = 0; c < 200; c++) begin
        int r;
        bus.fetch_en       = ($urandom_range(0, 9) != 0);
        bus.id_ready       = ($urandom_range(0, 3) > (ep % 3));
        bus.redirect_valid = ($urandom_range(0, 15) == 0);
        r = $urandom_range(0, 29);
        if (r == 0)      bus.redirect_pc = {58'($urandom_range(0, 15)), 2'b0, 2'($urandom_range(1, 3))} ;
        else if (r == 1) bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        else if (r < 5)  bus.redirect_pc = 64'($urandom_range(12, 15)) << 2;
        else             bus.redirect_pc = 64'($urandom_range(0, 15)) << 2;
        step();
      end
    end

    bus.redirect_valid = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
